// File: rtl/mips_pkg.sv
// Shared decode-stage definitions for the MIPS-style core.
// Opcodes, reg_dst encodings, field positions and the stage bundle.
package mips_pkg;

   localparam int DATA_W = 32;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [1:0] REGDST_RT   = 2'b00;
   localparam logic [1:0] REGDST_RD   = 2'b01;
   localparam logic [1:0] REGDST_LINK = 2'b10;

   localparam int OPC_LSB = 26;
   localparam int RS_LSB  = 21;
   localparam int RT_LSB  = 16;
   localparam int RD_LSB  = 11;
   localparam int SH_LSB  = 6;
   localparam int FN_LSB  = 0;
   localparam int IMM_LSB = 0;
   localparam int JA_LSB  = 0;

   localparam int OPC_W = 6;
   localparam int REG_W = 5;
   localparam int FN_W  = 6;
   localparam int IMM_W = 16;
   localparam int JA_W  = 26;

   typedef struct packed {
      logic              valid;
      logic [OPC_W-1:0]  opcode;
      logic [REG_W-1:0]  rs;
      logic [REG_W-1:0]  rt;
      logic [REG_W-1:0]  rd;
      logic [REG_W-1:0]  shamt;
      logic [FN_W-1:0]   funct;
      logic [IMM_W-1:0]  immediate;
      logic [DATA_W-1:0] imm_sext;
      logic [JA_W-1:0]   jump_addr;
      logic [DATA_W-1:0] alu_in1;
      logic [DATA_W-1:0] alu_in2;
      logic [DATA_W-1:0] write_data;
   } dec_stage_t;

endpackage

// File: rtl/decode_operand_select_field_split.sv
// Instruction field slicing and immediate sign extension.
// Pure bit selection; no opcode-dependent masking.
module instr_field_split
   import mips_pkg::*;
(
   input  logic [DATA_W-1:0] instr,
   output logic [OPC_W-1:0]  opcode,
   output logic [REG_W-1:0]  rs,
   output logic [REG_W-1:0]  rt,
   output logic [REG_W-1:0]  rd,
   output logic [REG_W-1:0]  shamt,
   output logic [FN_W-1:0]   funct,
   output logic [IMM_W-1:0]  immediate,
   output logic [DATA_W-1:0] imm_sext,
   output logic [JA_W-1:0]   jump_addr
);

   // Slice every field regardless of instruction format
   always_comb begin
      opcode    = instr[OPC_LSB +: OPC_W];
      rs        = instr[RS_LSB  +: REG_W];
      rt        = instr[RT_LSB  +: REG_W];
      rd        = instr[RD_LSB  +: REG_W];
      shamt     = instr[SH_LSB  +: REG_W];
      funct     = instr[FN_LSB  +: FN_W];
      immediate = instr[IMM_LSB +: IMM_W];
      jump_addr = instr[JA_LSB  +: JA_W];
      imm_sext  = {{(DATA_W-IMM_W){immediate[IMM_W-1]}}, immediate};
   end

endmodule

// File: rtl/decode_operand_select.sv
// Decode-stage operand and write-back select with registered outputs.
// One cycle from capture to outputs; reset clears everything.
module decode_operand_select
   import mips_pkg::*;
#(
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic [DW-1:0] instruction,
   input  logic [DW-1:0] read_data1,
   input  logic [DW-1:0] read_data2,
   input  logic          alu_src,
   input  logic          mem_to_reg,
   input  logic [1:0]    reg_dst,
   input  logic [DW-1:0] mem_data,
   input  logic [DW-1:0] pc_plus_one,
   input  logic [DW-1:0] alu_result,
   output logic          out_valid,
   output logic [5:0]    opcode,
   output logic [4:0]    rs,
   output logic [4:0]    rt,
   output logic [4:0]    rd,
   output logic [4:0]    shamt,
   output logic [5:0]    funct,
   output logic [15:0]   immediate,
   output logic [DW-1:0] imm_sext,
   output logic [25:0]   jump_addr,
   output logic [DW-1:0] alu_in1,
   output logic [DW-1:0] alu_in2,
   output logic [DW-1:0] write_data
);

   logic [OPC_W-1:0]  f_opcode;
   logic [REG_W-1:0]  f_rs;
   logic [REG_W-1:0]  f_rt;
   logic [REG_W-1:0]  f_rd;
   logic [REG_W-1:0]  f_shamt;
   logic [FN_W-1:0]   f_funct;
   logic [IMM_W-1:0]  f_imm;
   logic [DATA_W-1:0] f_sext;
   logic [JA_W-1:0]   f_jaddr;

   logic [DATA_W-1:0] opb;
   logic [DATA_W-1:0] wb_data;

   dec_stage_t stage_d;
   dec_stage_t stage_q;

   instr_field_split u_split (
      .instr     (instruction),
      .opcode    (f_opcode),
      .rs        (f_rs),
      .rt        (f_rt),
      .rd        (f_rd),
      .shamt     (f_shamt),
      .funct     (f_funct),
      .immediate (f_imm),
      .imm_sext  (f_sext),
      .jump_addr (f_jaddr)
   );

   // Operand B: immediate or rt register data
   always_comb begin
      opb = read_data2;
      if (alu_src) begin
         opb = f_sext;
      end
   end

   // Write-back: link beats load beats ALU
   always_comb begin
      wb_data = alu_result;
      if (reg_dst == REGDST_LINK) begin
         wb_data = pc_plus_one;
      end else if (mem_to_reg) begin
         wb_data = mem_data;
      end
   end

   // Next stage contents: load on in_valid, else hold data
   always_comb begin
      stage_d       = stage_q;
      stage_d.valid = 1'b0;
      if (in_valid) begin
         stage_d.valid      = 1'b1;
         stage_d.opcode     = f_opcode;
         stage_d.rs         = f_rs;
         stage_d.rt         = f_rt;
         stage_d.rd         = f_rd;
         stage_d.shamt      = f_shamt;
         stage_d.funct      = f_funct;
         stage_d.immediate  = f_imm;
         stage_d.imm_sext   = f_sext;
         stage_d.jump_addr  = f_jaddr;
         stage_d.alu_in1    = read_data1;
         stage_d.alu_in2    = opb;
         stage_d.write_data = wb_data;
      end
   end

   // Stage register with synchronous active-low clear
   always_ff @(posedge clk) begin
      if (!rst) begin
         stage_q <= '0;
      end else begin
         stage_q <= stage_d;
      end
   end

   assign out_valid  = stage_q.valid;
   assign opcode     = stage_q.opcode;
   assign rs         = stage_q.rs;
   assign rt         = stage_q.rt;
   assign rd         = stage_q.rd;
   assign shamt      = stage_q.shamt;
   assign funct      = stage_q.funct;
   assign immediate  = stage_q.immediate;
   assign imm_sext   = stage_q.imm_sext;
   assign jump_addr  = stage_q.jump_addr;
   assign alu_in1    = stage_q.alu_in1;
   assign alu_in2    = stage_q.alu_in2;
   assign write_data = stage_q.write_data;

endmodule

// File: tb/tb_decode_operand_select.sv
// Self-checking bench for decode_operand_select.
// Table vectors, reset/hold sequences and random traffic vs a model.
module tb_decode_operand_select;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [31:0] instruction;
   logic [31:0] read_data1;
   logic [31:0] read_data2;
   logic        alu_src;
   logic        mem_to_reg;
   logic [1:0]  reg_dst;
   logic [31:0] mem_data;
   logic [31:0] pc_plus_one;
   logic [31:0] alu_result;
   logic        out_valid;
   logic [5:0]  opcode;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [4:0]  shamt;
   logic [5:0]  funct;
   logic [15:0] immediate;
   logic [31:0] imm_sext;
   logic [25:0] jump_addr;
   logic [31:0] alu_in1;
   logic [31:0] alu_in2;
   logic [31:0] write_data;

   int n_chk  = 0;
   int n_pass = 0;

   // model state: expected registered outputs
   logic [31:0] m_valid, m_op, m_rs, m_rt, m_rd, m_sh, m_fn;
   logic [31:0] m_imm, m_sext, m_ja, m_in1, m_in2, m_wd;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] rd2;
      logic        asrc;
      logic        m2r;
      logic [1:0]  rdst;
      logic [31:0] mem;
      logic [31:0] pc;
      logic [31:0] alu;
      logic [31:0] e_op;
      logic [31:0] e_rs;
      logic [31:0] e_rt;
      logic [31:0] e_rd;
      logic [31:0] e_fn;
      logic [31:0] e_sext;
      logic [31:0] e_in2;
      logic [31:0] e_wd;
      logic [31:0] e_ja;
   } vec_t;

   vec_t vecs[7];

   always #5 clk = ~clk;

   decode_operand_select dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .instruction (instruction),
      .read_data1  (read_data1),
      .read_data2  (read_data2),
      .alu_src     (alu_src),
      .mem_to_reg  (mem_to_reg),
      .reg_dst     (reg_dst),
      .mem_data    (mem_data),
      .pc_plus_one (pc_plus_one),
      .alu_result  (alu_result),
      .out_valid   (out_valid),
      .opcode      (opcode),
      .rs          (rs),
      .rt          (rt),
      .rd          (rd),
      .shamt       (shamt),
      .funct       (funct),
      .immediate   (immediate),
      .imm_sext    (imm_sext),
      .jump_addr   (jump_addr),
      .alu_in1     (alu_in1),
      .alu_in2     (alu_in2),
      .write_data  (write_data)
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic randomize_inputs();
      instruction = $urandom;
      read_data1  = $urandom;
      read_data2  = $urandom;
      alu_src     = 1'($urandom_range(0, 1));
      mem_to_reg  = 1'($urandom_range(0, 1));
      reg_dst     = 2'($urandom_range(0, 3));
      mem_data    = $urandom;
      pc_plus_one = $urandom;
      alu_result  = $urandom;
   endtask

   // model prediction from the current inputs, using plain arithmetic
   task automatic predict();
      logic [31:0] lo16;
      if (rst == 1'b0) begin
         {m_valid, m_op, m_rs, m_rt, m_rd, m_sh, m_fn} = '0;
         {m_imm, m_sext, m_ja, m_in1, m_in2, m_wd} = '0;
      end else if (in_valid) begin
         lo16    = instruction % 32'h10000;
         m_valid = 1;
         m_op    = instruction / (1 << 26);
         m_rs    = (instruction / (1 << 21)) % 32;
         m_rt    = (instruction / (1 << 16)) % 32;
         m_rd    = (instruction / (1 << 11)) % 32;
         m_sh    = (instruction / 64) % 32;
         m_fn    = instruction % 64;
         m_imm   = lo16;
         m_sext  = (lo16 >= 32'h8000) ? lo16 + 32'hFFFF0000 : lo16;
         m_ja    = instruction % (1 << 26);
         m_in1   = read_data1;
         m_in2   = alu_src ? m_sext : read_data2;
         if (reg_dst == 2'd2) m_wd = pc_plus_one;
         else if (mem_to_reg) m_wd = mem_data;
         else m_wd = alu_result;
      end else begin
         m_valid = 0;
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".out_valid"}, 32'(out_valid), m_valid);
      chk({tag, ".opcode"}, 32'(opcode), m_op);
      chk({tag, ".rs"}, 32'(rs), m_rs);
      chk({tag, ".rt"}, 32'(rt), m_rt);
      chk({tag, ".rd"}, 32'(rd), m_rd);
      chk({tag, ".shamt"}, 32'(shamt), m_sh);
      chk({tag, ".funct"}, 32'(funct), m_fn);
      chk({tag, ".immediate"}, 32'(immediate), m_imm);
      chk({tag, ".imm_sext"}, imm_sext, m_sext);
      chk({tag, ".jump_addr"}, 32'(jump_addr), m_ja);
      chk({tag, ".alu_in1"}, alu_in1, m_in1);
      chk({tag, ".alu_in2"}, alu_in2, m_in2);
      chk({tag, ".write_data"}, write_data, m_wd);
   endtask

   // inputs are set after posedge+1; outputs checked at next posedge+1
   task automatic cycle(input string tag);
      predict();
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   initial begin
      vecs[0] = '{32'h012A4020, 32'h5, 1'b0, 1'b0, 2'b01, 32'h22,
                  32'h33, 32'h11, 32'h0, 32'd9, 32'd10, 32'd8,
                  32'h20, 32'h4020, 32'h5, 32'h11, 32'h12A4020};
      vecs[1] = '{32'h2128FFFC, 32'h12345678, 1'b1, 1'b0, 2'b00,
                  32'h22, 32'h33, 32'h11, 32'h08, 32'd9, 32'd8,
                  32'd31, 32'h3C, 32'hFFFFFFFC, 32'hFFFFFFFC,
                  32'h11, 32'h128FFFC};
      vecs[2] = '{32'h2128FFFC, 32'h12345678, 1'b0, 1'b1, 2'b00,
                  32'h22, 32'h33, 32'h11, 32'h08, 32'd9, 32'd8,
                  32'd31, 32'h3C, 32'hFFFFFFFC, 32'h12345678,
                  32'h22, 32'h128FFFC};
      vecs[3] = '{32'h0C0003FF, 32'h0, 1'b0, 1'b1, 2'b10, 32'h22,
                  32'h33, 32'h11, 32'h03, 32'd0, 32'd0, 32'd0,
                  32'h3F, 32'h3FF, 32'h0, 32'h33, 32'h00003FF};
      vecs[4] = '{32'h8C018000, 32'h0, 1'b1, 1'b0, 2'b11, 32'h22,
                  32'h33, 32'h11, 32'h23, 32'd0, 32'd1, 32'd16,
                  32'h0, 32'hFFFF8000, 32'hFFFF8000, 32'h11,
                  32'h0018000};
      vecs[5] = '{32'hAC027FFF, 32'h0, 1'b1, 1'b1, 2'b11, 32'h22,
                  32'h33, 32'h11, 32'h2B, 32'd0, 32'd2, 32'd15,
                  32'h3F, 32'h7FFF, 32'h7FFF, 32'h22, 32'h0027FFF};
      vecs[6] = '{32'h08000000, 32'hA5A5A5A5, 1'b0, 1'b0, 2'b00,
                  32'h22, 32'h33, 32'h11, 32'h02, 32'd0, 32'd0,
                  32'd0, 32'h0, 32'h0, 32'hA5A5A5A5, 32'h11,
                  32'h0};

      // reset held for two cycles with busy inputs
      rst = 1'b0;
      in_valid = 1'b1;
      randomize_inputs();
      #1;
      for (int i = 0; i < 2; i++) begin
         randomize_inputs();
         cycle("reset");
         chk("reset.valid_low", 32'(out_valid), 32'h0);
         chk("reset.wd_zero", write_data, 32'h0);
      end

      // table vectors, first one is the first capture after reset
      rst = 1'b1;
      for (int i = 0; i < 7; i++) begin
         in_valid    = 1'b1;
         instruction = vecs[i].instr;
         read_data1  = 32'hCAFE0000 + 32'(i);
         read_data2  = vecs[i].rd2;
         alu_src     = vecs[i].asrc;
         mem_to_reg  = vecs[i].m2r;
         reg_dst     = vecs[i].rdst;
         mem_data    = vecs[i].mem;
         pc_plus_one = vecs[i].pc;
         alu_result  = vecs[i].alu;
         cycle($sformatf("vec%0d", i));
         chk($sformatf("vec%0d.op", i), 32'(opcode), vecs[i].e_op);
         chk($sformatf("vec%0d.rs", i), 32'(rs), vecs[i].e_rs);
         chk($sformatf("vec%0d.rt", i), 32'(rt), vecs[i].e_rt);
         chk($sformatf("vec%0d.rd", i), 32'(rd), vecs[i].e_rd);
         chk($sformatf("vec%0d.fn", i), 32'(funct), vecs[i].e_fn);
         chk($sformatf("vec%0d.sext", i), imm_sext, vecs[i].e_sext);
         chk($sformatf("vec%0d.in2", i), alu_in2, vecs[i].e_in2);
         chk($sformatf("vec%0d.wd", i), write_data, vecs[i].e_wd);
         chk($sformatf("vec%0d.ja", i), 32'(jump_addr), vecs[i].e_ja);
         chk($sformatf("vec%0d.valid", i), 32'(out_valid), 32'h1);
      end

      // hold: in_valid low keeps data, drops valid
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b0;
         randomize_inputs();
         cycle("hold");
         chk("hold.valid", 32'(out_valid), 32'h0);
         chk("hold.jaddr", 32'(jump_addr), 32'h0);
         chk("hold.in2", alu_in2, 32'hA5A5A5A5);
      end

      // mid-run reset overrides a capture
      in_valid = 1'b1;
      randomize_inputs();
      cycle("reload");
      rst = 1'b0;
      randomize_inputs();
      cycle("midrst");
      chk("midrst.valid", 32'(out_valid), 32'h0);
      chk("midrst.in1", alu_in1, 32'h0);
      rst = 1'b1;

      // random traffic against the model
      for (int i = 0; i < 300; i++) begin
         rst      = ($urandom_range(0, 19) != 0);
         in_valid = 1'($urandom_range(0, 3) != 0);
         randomize_inputs();
         cycle("rand");
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
